// File: rtl/counter_counter_pkg.sv
// rtl/counter_counter_pkg.sv - defaults for the modulo-MAX counter primitive
package counter_counter_pkg;

    localparam int COUNTER_COUNTER_MAX_DEFAULT = 12;
    localparam int COUNTER_COUNTER_MAX_MIN     = 2;

endpackage

// File: rtl/util_control_pkg.sv
// rtl/util_control_pkg.sv - shared control bundle carrying clock and active-low reset
package Util_Control;

    typedef struct packed {
        logic clock;
        logic reset;
    } Util_Control_T;

    function automatic logic util_clock(input Util_Control_T c);
        return c.clock;
    endfunction

    function automatic logic util_reset(input Util_Control_T c);
        return c.reset;
    endfunction

endpackage

// File: rtl/counter_counter.sv
// rtl/counter_counter.sv - modulo-MAX up-counter with synchronous load and enable
// Optional macro COUNTER_COUNTER_SATURATE_EN: hold at MAX-1 instead of wrapping.
module counter_counter
    import Util_Control::*;
    import counter_counter_pkg::*;
#(
    parameter int MAX   = COUNTER_COUNTER_MAX_DEFAULT,
    parameter int WIDTH = $clog2(MAX)
) (
    input  Util_Control_T    ctrl,
    input  logic             load,
    input  logic             enable,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    localparam logic [WIDTH-1:0] LP_LAST = WIDTH'(MAX - 1);

    generate
        if (MAX < COUNTER_COUNTER_MAX_MIN) begin : g_bad_max
            $error("counter_counter: MAX must be >= 2");
        end
    endgenerate

    logic             w_clk;
    logic             w_rst_n;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_next;

    assign w_clk   = util_clock(ctrl);
    assign w_rst_n = util_reset(ctrl);

    // Terminal count is tested before the add so non-power-of-two MAX never overflows into illegal codes.
    always_comb begin
        w_q_next = r_q;
        if (!w_rst_n) begin
            w_q_next = '0;
        end else if (load) begin
            w_q_next = (d <= LP_LAST) ? d : '0;
        end else if (enable) begin
            if (r_q == LP_LAST) begin
`ifdef COUNTER_COUNTER_SATURATE_EN
                w_q_next = LP_LAST;
`else
                w_q_next = '0;
`endif
            end else begin
                w_q_next = r_q + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_q <= '0;
        end else begin
            r_q <= w_q_next;
        end
    end

    assign q = r_q;

endmodule

// File: tb/tb_counter_counter.sv
// tb/tb_counter_counter.sv - directed scoreboard bench for counter_counter (MAX=12)
module tb_counter_counter;
    import Util_Control::*;

    localparam int MAX   = 12;
    localparam int WIDTH = 4;

    logic             clk;
    logic             rst_n;
    logic             load;
    logic             enable;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    Util_Control_T    ctrl;

    int n_total;
    int n_pass;

    typedef struct {
        string            tag;
        logic [WIDTH-1:0] val;
    } exp_t;

    exp_t sb[$];

    assign ctrl.clock = clk;
    assign ctrl.reset = rst_n;

    counter_counter #(.MAX(MAX)) dut (
        .ctrl   (ctrl),
        .load   (load),
        .enable (enable),
        .d      (d),
        .q      (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: q=%0d expected=%0d", tag, obs, exp);
    endtask

    // Drive at the falling edge, push the expectation, clock once, compare at the next falling edge.
    task automatic step(input string tag, input logic l, input logic e,
                        input logic [WIDTH-1:0] dv, input logic [WIDTH-1:0] exp);
        exp_t item;
        exp_t got;
        load   = l;
        enable = e;
        d      = dv;
        item.tag = tag;
        item.val = exp;
        sb.push_back(item);
        @(posedge clk);
        @(negedge clk);
        if (sb.size() == 0) begin
            n_total++;
            $error("FAIL %s: scoreboard empty, q=%0d", tag, q);
        end else begin
            got = sb.pop_front();
            check(got.tag, q, got.val);
        end
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst_n   = 1'b0;
        load    = 1'b0;
        enable  = 1'b1;
        d       = '0;

        @(negedge clk);
        step("reset_hold0", 1'b0, 1'b1, 4'd0, 4'd0);
        step("reset_hold1", 1'b0, 1'b1, 4'd0, 4'd0);

        rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
`ifdef COUNTER_COUNTER_SATURATE_EN
            step($sformatf("count_%0d", k), 1'b0, 1'b1, 4'd0, WIDTH'((k < MAX) ? k : MAX - 1));
`else
            step($sformatf("count_%0d", k), 1'b0, 1'b1, 4'd0, WIDTH'(k % MAX));
`endif
        end

        step("load_5", 1'b1, 1'b0, 4'd5, 4'd5);
        for (int k = 0; k < 4; k++) step($sformatf("hold_%0d", k), 1'b0, 1'b0, 4'd9, 4'd5);
        step("load_14_oor", 1'b1, 1'b0, 4'd14, 4'd0);
        step("load_7_en0", 1'b1, 1'b0, 4'd7, 4'd7);

        // Asynchronous reset away from any rising edge.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", q, 4'd0);
        @(negedge clk);
        step("reset_during_load", 1'b1, 1'b1, 4'd9, 4'd0);

        rst_n = 1'b1;
        step("post_reset_hold0", 1'b0, 1'b0, 4'd9, 4'd0);
        step("post_reset_hold1", 1'b0, 1'b0, 4'd9, 4'd0);

        step("prio_load_3", 1'b1, 1'b1, 4'd3, 4'd3);
        step("prio_then_count", 1'b0, 1'b1, 4'd3, 4'd4);

        step("load_11", 1'b1, 1'b0, 4'd11, 4'd11);
`ifdef COUNTER_COUNTER_SATURATE_EN
        step("terminal_step", 1'b0, 1'b1, 4'd0, 4'd11);
`else
        step("terminal_step", 1'b0, 1'b1, 4'd0, 4'd0);
`endif
        step("load_12_boundary", 1'b1, 1'b0, 4'd12, 4'd0);
        step("load_11_again", 1'b1, 1'b1, 4'd11, 4'd11);
        step("load_15_oor", 1'b1, 1'b0, 4'd15, 4'd0);

        n_total++;
        assert (sb.size() == 0) n_pass++;
        else $error("FAIL scoreboard_drain: left=%0d expected=0", sb.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
